// File: rtl/match_sequencer.sv
// Pong game-flow controller: serve, rally, point pause, game over and both scores.
// Optional AUTO_SERVE_EN builds a frame-count timer that serves without the button.
module match_sequencer #(
  parameter int p_WIN_SCORE      = 9,
  parameter int p_POINT_FRAMES   = 60,
  parameter int p_HITS_PER_LEVEL = 4,
  parameter int p_SERVE_FRAMES   = 120
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VReset,
  input  logic       i_Serve,
  input  logic       i_Hit,
  input  logic       i_Miss_Left,
  input  logic       i_Miss_Right,
  output logic       o_Ball_Enable,
  output logic       o_Ball_Restart,
  output logic       o_Serve_HDir,
  output logic [1:0] o_Speed,
  output logic [3:0] o_Score_Left,
  output logic [3:0] o_Score_Right,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam int c_FRAME_MAX = (p_POINT_FRAMES > p_SERVE_FRAMES) ? p_POINT_FRAMES : p_SERVE_FRAMES;
  localparam int c_FRAME_W   = $clog2(c_FRAME_MAX + 1);
  localparam logic [3:0] c_WIN = 4'(p_WIN_SCORE);
  localparam logic [c_FRAME_W-1:0] c_POINT_LAST = c_FRAME_W'(p_POINT_FRAMES - 1);
`ifdef AUTO_SERVE_EN
  localparam logic [c_FRAME_W-1:0] c_SERVE_LAST = c_FRAME_W'(p_SERVE_FRAMES - 1);
`endif

  function automatic logic [1:0] speed_level(input logic [7:0] hits);
    int level_v;
    level_v = int'(hits) / p_HITS_PER_LEVEL;
    if (level_v > 3) return 2'd3;
    else             return 2'(level_v);
  endfunction

  // Scores saturate at the winning value so they can never wrap.
  function automatic logic [3:0] score_inc(input logic [3:0] score);
    if (score >= c_WIN) return c_WIN;
    else                return score + 4'd1;
  endfunction

  state_t                 state_r;
  logic [3:0]             score_left_r;
  logic [3:0]             score_right_r;
  logic [1:0]             speed_r;
  logic                   serve_hdir_r;
  logic                   ball_enable_r;
  logic                   ball_restart_r;
  logic                   game_over_r;
  logic [c_FRAME_W-1:0]   frame_cnt_r;
  logic [7:0]             hit_cnt_r;
  logic                   serve_prev_r;

  logic                   serve_edge_s;
  logic                   serve_go_s;
  logic [7:0]             hit_next_s;

  assign serve_edge_s = i_Serve & ~serve_prev_r;
  assign hit_next_s   = (hit_cnt_r == 8'd255) ? 8'd255 : hit_cnt_r + 8'd1;
`ifdef AUTO_SERVE_EN
  assign serve_go_s   = serve_edge_s | (i_VReset & (frame_cnt_r == c_SERVE_LAST));
`else
  assign serve_go_s   = serve_edge_s;
`endif

  // Match state machine with all outputs held in registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r        <= ST_IDLE;
      score_left_r   <= 4'd0;
      score_right_r  <= 4'd0;
      speed_r        <= 2'd0;
      serve_hdir_r   <= 1'b1;
      ball_enable_r  <= 1'b0;
      ball_restart_r <= 1'b0;
      game_over_r    <= 1'b0;
      frame_cnt_r    <= '0;
      hit_cnt_r      <= 8'd0;
      serve_prev_r   <= 1'b0;
    end else begin
      serve_prev_r   <= i_Serve;
      ball_restart_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ball_enable_r  <= 1'b0;
          ball_restart_r <= 1'b1;
          frame_cnt_r    <= '0;
          state_r        <= ST_SERVE_WAIT;
        end
        ST_SERVE_WAIT: begin
          ball_enable_r <= 1'b0;
          if (serve_go_s) begin
            state_r       <= ST_PLAY;
            ball_enable_r <= 1'b1;
            hit_cnt_r     <= 8'd0;
            speed_r       <= 2'd0;
          end else begin
`ifdef AUTO_SERVE_EN
            if (i_VReset) frame_cnt_r <= frame_cnt_r + 1'b1;
`endif
          end
        end
        ST_PLAY: begin
          // A miss always wins over a simultaneous hit; left wins over right.
          if (i_Miss_Left) begin
            score_right_r <= score_inc(score_right_r);
            serve_hdir_r  <= 1'b0;
            ball_enable_r <= 1'b0;
            frame_cnt_r   <= '0;
            state_r       <= ST_POINT;
          end else if (i_Miss_Right) begin
            score_left_r  <= score_inc(score_left_r);
            serve_hdir_r  <= 1'b1;
            ball_enable_r <= 1'b0;
            frame_cnt_r   <= '0;
            state_r       <= ST_POINT;
          end else if (i_Hit) begin
            hit_cnt_r <= hit_next_s;
            speed_r   <= speed_level(hit_next_s);
          end
        end
        ST_POINT: begin
          ball_enable_r <= 1'b0;
          if (score_left_r == c_WIN || score_right_r == c_WIN) begin
            game_over_r <= 1'b1;
            state_r     <= ST_GAME_OVER;
          end else if (i_VReset) begin
            if (frame_cnt_r == c_POINT_LAST) begin
              frame_cnt_r    <= '0;
              ball_restart_r <= 1'b1;
              state_r        <= ST_SERVE_WAIT;
            end else begin
              frame_cnt_r <= frame_cnt_r + 1'b1;
            end
          end
        end
        ST_GAME_OVER: begin
          ball_enable_r <= 1'b0;
          game_over_r   <= 1'b1;
          if (serve_edge_s) begin
            score_left_r   <= 4'd0;
            score_right_r  <= 4'd0;
            serve_hdir_r   <= 1'b1;
            game_over_r    <= 1'b0;
            frame_cnt_r    <= '0;
            ball_restart_r <= 1'b1;
            state_r        <= ST_SERVE_WAIT;
          end
        end
        default: begin
          ball_enable_r <= 1'b0;
          game_over_r   <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Ball_Enable  = ball_enable_r;
  assign o_Ball_Restart = ball_restart_r;
  assign o_Serve_HDir   = serve_hdir_r;
  assign o_Speed        = speed_r;
  assign o_Score_Left   = score_left_r;
  assign o_Score_Right  = score_right_r;
  assign o_Game_Over    = game_over_r;
  assign o_State        = state_r;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed vector table, frame-timing
// sequences, and randomized rallies scored by a rally-level model.
module tb_match_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Reset, i_VReset, i_Serve, i_Hit, i_Miss_Left, i_Miss_Right;
  logic       o_Ball_Enable, o_Ball_Restart, o_Serve_HDir, o_Game_Over;
  logic [1:0] o_Speed;
  logic [3:0] o_Score_Left, o_Score_Right;
  logic [2:0] o_State;

  int checks   = 0;
  int failures = 0;

  match_sequencer dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_VReset(i_VReset), .i_Serve(i_Serve),
    .i_Hit(i_Hit), .i_Miss_Left(i_Miss_Left), .i_Miss_Right(i_Miss_Right),
    .o_Ball_Enable(o_Ball_Enable), .o_Ball_Restart(o_Ball_Restart),
    .o_Serve_HDir(o_Serve_HDir), .o_Speed(o_Speed), .o_Score_Left(o_Score_Left),
    .o_Score_Right(o_Score_Right), .o_Game_Over(o_Game_Over), .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int s, h, ml, mr, vr;
    int st, en, rs, spd, sl, sr, hd, go;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(int s, int h, int ml, int mr, int vr, int st, int en,
                              int rs, int spd, int sl, int sr, int hd, int go);
    vec_t v;
    v.s = s; v.h = h; v.ml = ml; v.mr = mr; v.vr = vr;
    v.st = st; v.en = en; v.rs = rs; v.spd = spd;
    v.sl = sl; v.sr = sr; v.hd = hd; v.go = go;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int st, input int en, input int rs,
                           input int spd, input int sl, input int sr, input int hd, input int go);
    chk($sformatf("%s.state", name),   int'(o_State),        st);
    chk($sformatf("%s.enable", name),  int'(o_Ball_Enable),  en);
    chk($sformatf("%s.restart", name), int'(o_Ball_Restart), rs);
    chk($sformatf("%s.speed", name),   int'(o_Speed),        spd);
    chk($sformatf("%s.score_l", name), int'(o_Score_Left),   sl);
    chk($sformatf("%s.score_r", name), int'(o_Score_Right),  sr);
    chk($sformatf("%s.hdir", name),    int'(o_Serve_HDir),   hd);
    chk($sformatf("%s.game_over", name), int'(o_Game_Over),  go);
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input int s, input int h, input int ml, input int mr, input int vr);
    i_Serve = (s != 0); i_Hit = (h != 0); i_Miss_Left = (ml != 0);
    i_Miss_Right = (mr != 0); i_VReset = (vr != 0);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wait_restart(input int budget, input int s, output int found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (o_Ball_Restart) begin
        found = 1;
        break;
      end
      step(s, 0, 0, 0, 0);
    end
  endtask

  function automatic int lvl(int hits);
    return (hits / 4 > 3) ? 3 : hits / 4;
  endfunction

  int sl, sr, hd, h, n, gap, side, hh, found, over, rally, spd;

  initial begin
    // s h ml mr vr | st en rs spd sl sr hd go
    vecs[0]  = mk(0,0,0,0,0, 1,0,1,0, 0,0,1,0);
    vecs[1]  = mk(0,0,0,0,0, 1,0,0,0, 0,0,1,0);
    vecs[2]  = mk(0,1,1,0,0, 1,0,0,0, 0,0,1,0);
    vecs[3]  = mk(1,0,0,0,0, 2,1,0,0, 0,0,1,0);
    vecs[4]  = mk(0,1,0,0,0, 2,1,0,0, 0,0,1,0);
    vecs[5]  = mk(0,1,0,0,0, 2,1,0,0, 0,0,1,0);
    vecs[6]  = mk(0,1,0,0,0, 2,1,0,0, 0,0,1,0);
    vecs[7]  = mk(0,1,0,0,0, 2,1,0,1, 0,0,1,0);
    vecs[8]  = mk(0,0,0,0,0, 2,1,0,1, 0,0,1,0);
    vecs[9]  = mk(0,1,0,0,0, 2,1,0,1, 0,0,1,0);
    vecs[10] = mk(0,1,0,0,0, 2,1,0,1, 0,0,1,0);
    vecs[11] = mk(0,1,0,0,0, 2,1,0,1, 0,0,1,0);
    vecs[12] = mk(0,1,0,0,0, 2,1,0,2, 0,0,1,0);
    vecs[13] = mk(0,1,0,0,0, 2,1,0,2, 0,0,1,0);
    vecs[14] = mk(0,1,1,1,0, 3,0,0,2, 0,1,0,0);
    vecs[15] = mk(0,0,0,1,0, 3,0,0,2, 0,1,0,0);
    vecs[16] = mk(1,1,1,0,0, 3,0,0,2, 0,1,0,0);

    i_Reset = 1'b1; i_VReset = 1'b0; i_Serve = 1'b0; i_Hit = 1'b0;
    i_Miss_Left = 1'b0; i_Miss_Right = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0, 1, 0);
    i_Reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].s, vecs[i].h, vecs[i].ml, vecs[i].mr, vecs[i].vr);
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].rs, vecs[i].spd,
                vecs[i].sl, vecs[i].sr, vecs[i].hd, vecs[i].go);
    end

    // Point pause lasts exactly 60 frames; stray pulses in between change nothing.
    for (int f = 1; f <= 60; f++) begin
      step(0, 0, 0, 0, 1);
      if (f < 60) begin
        chk("point_hold.state", int'(o_State), 3);
        chk("point_hold.restart", int'(o_Ball_Restart), 0);
        step(0, 1, 1, 1, 0);
        chk("point_hold.score_r", int'(o_Score_Right), 1);
      end
    end
    wait_restart(4, 0, found);
    chk("point_exit.found", found, 1);
    check_out("point_exit", 1, 0, 1, 2, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("point_exit.pulse_width", int'(o_Ball_Restart), 0);

    // Randomized rallies until someone reaches the winning score.
    sl = 0; sr = 1; hd = 0; over = 0; rally = 0; spd = 2;
    while (over == 0 && rally < 40) begin
      rally++;
      step(0, 0, 0, 0, 0);
      chk("rally.wait_state", int'(o_State), 1);
      step(1, 0, 0, 0, 0);
      check_out("rally.serve", 2, 1, 0, 0, sl, sr, hd, 0);
      h = 0;
      n = $urandom_range(0, 14);
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          step($urandom % 2, 0, 0, 0, $urandom % 2);
          chk("rally.gap_speed", int'(o_Speed), lvl(h));
        end
        step($urandom % 2, 1, 0, 0, 0);
        h++;
        chk("rally.hit_speed", int'(o_Speed), lvl(h));
        chk("rally.hit_state", int'(o_State), 2);
      end
      side = $urandom_range(0, 2);
      hh = $urandom % 2;
      step(1, hh, (side != 1) ? 1 : 0, (side != 0) ? 1 : 0, 0);
      if (side != 1) begin
        sr = (sr < 9) ? sr + 1 : 9;
        hd = 0;
      end else begin
        sl = (sl < 9) ? sl + 1 : 9;
        hd = 1;
      end
      spd = lvl(h);
      check_out("rally.miss", 3, 0, 0, spd, sl, sr, hd, 0);
      if (sl == 9 || sr == 9) begin
        step(1, 0, 0, 0, 0);
        check_out("game_over", 4, 0, 0, spd, sl, sr, hd, 1);
        over = 1;
      end else begin
        for (int f = 1; f <= 60; f++) begin
          step(1, 0, 0, 0, 1);
          if (f < 60) begin
            chk("rally.point_state", int'(o_State), 3);
            step(1, $urandom % 2, $urandom % 2, $urandom % 2, 0);
          end
        end
        wait_restart(4, 1, found);
        chk("rally.restart_found", found, 1);
        check_out("rally.restart", 1, 0, 1, spd, sl, sr, hd, 0);
      end
    end
    chk("game_reached_end", over, 1);

    // Serve held from the final point: no exit until released and pressed again.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 1);
      check_out("go_hold", 4, 0, 0, spd, sl, sr, hd, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("go_release.state", int'(o_State), 4);
    step(1, 0, 0, 0, 0);
    check_out("go_restart", 1, 0, 1, spd, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("go_restart.pulse_width", int'(o_Ball_Restart), 0);

`ifdef AUTO_SERVE_EN
    for (int f = 1; f <= 120; f++) begin
      step(0, 0, 0, 0, 1);
      if (f < 120) begin
        chk("auto.wait_state", int'(o_State), 1);
        step(0, 0, 0, 0, 0);
      end
    end
    found = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_State == 3'd2) begin
        found = 1;
        break;
      end
      step(0, 0, 0, 0, 0);
    end
    chk("auto.served", found, 1);
    chk("auto.enable", int'(o_Ball_Enable), 1);
`else
    for (int f = 0; f < 500; f++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    chk("no_auto.state", int'(o_State), 1);
    chk("no_auto.enable", int'(o_Ball_Enable), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
